decoder_pipe: RTL and testbench

Parametrised, pipelined successor to the team's 5-to-32 combinational opcode decoder. It accepts an opcode plus enable through a valid/ready handshake and produces a registered one-hot word. It flags opcodes with no output line and keeps a saturating count of those illegal opcodes. A 2-entry elastic output stage keeps full throughput under downstream backpressure. It sits between instruction fetch/issue and the ALU unit-select logic.

---
 rtl/decoder_pkg.sv | 15 +
 rtl/decoder_skid.sv | 70 +++++++
 rtl/decoder_pipe.sv | 96 +++++++++
 tb/tb_decoder_pipe.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared constants and result layout for the opcode decoder
package decoder_pkg;

   localparam int DEC_IN_W  = 5;
   localparam int DEC_OUT_W = 32;
   localparam int DEC_CNT_W = 8;

   // Result word held in each elastic-buffer entry (default configuration layout)
   typedef struct packed {
      logic [DEC_OUT_W-1:0] onehot;
      logic                 illegal;
      logic [DEC_IN_W-1:0]  opcode;
   } dec_result_t;

endpackage

// File: rtl/decoder_skid.sv
// rtl/decoder_skid.sv - generic 2-entry valid/ready elastic buffer (main + skid)
module decoder_skid #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] in_data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] out_data_o
);

   logic         main_valid_q, main_valid_d;
   logic         skid_valid_q, skid_valid_d;
   logic [W-1:0] main_data_q, main_data_d;
   logic [W-1:0] skid_data_q, skid_data_d;
   logic         accept;
   logic         drain;

   // in_ready comes straight from the skid flag so out_ready never reaches it combinationally
   assign in_ready_o  = ~skid_valid_q;
   assign accept      = in_valid_i & ~skid_valid_q;
   assign drain       = main_valid_q & out_ready_i;
   assign out_valid_o = main_valid_q;
   assign out_data_o  = main_data_q;

   // Occupancy transitions: skid refills main on drain, new items fill main first then skid
   always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (drain) begin
         if (skid_valid_q) begin
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            main_data_d = in_data_i;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (accept) begin
         if (main_valid_q) begin
            skid_data_d  = in_data_i;
            skid_valid_d = 1'b1;
         end else begin
            main_data_d  = in_data_i;
            main_valid_d = 1'b1;
         end
      end
   end

   // Buffer registers; reset discards everything held
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid_q <= 1'b0;
         main_data_q  <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         main_data_q  <= main_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
      end
   end

endmodule

// File: rtl/decoder_pipe.sv
// rtl/decoder_pipe.sv - pipelined one-hot opcode decoder with illegal-opcode counter
module decoder_pipe
   import decoder_pkg::*;
#(
   parameter int IN_W  = DEC_IN_W,
   parameter int OUT_W = DEC_OUT_W,
   parameter int CNT_W = DEC_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_opcode,
   input  logic             in_enable,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_onehot,
   output logic             out_illegal,
   output logic [IN_W-1:0]  out_opcode,
   output logic [CNT_W-1:0] illegal_cnt,
   input  logic             cnt_clr
);

   // Same field order as dec_result_t, sized by this instance's parameters
   typedef struct packed {
      logic [OUT_W-1:0] onehot;
      logic             illegal;
      logic [IN_W-1:0]  opcode;
   } result_t;

   localparam int               RES_W   = $bits(result_t);
   localparam logic [IN_W:0]    OUT_W_L = (IN_W + 1)'(OUT_W);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   if (IN_W < 1 || IN_W > 8 || CNT_W < 1 || CNT_W > 16 ||
       OUT_W < 2 || OUT_W > (1 << IN_W)) begin : g_bad_params
      $error("decoder_pipe: illegal IN_W/OUT_W/CNT_W combination");
   end

   result_t          dec_res;
   result_t          out_res;
   logic [RES_W-1:0] out_bits;
   logic             accept;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Decode: opcodes with no output line flag illegal; disabled items decode to all-zero
   always_comb begin
      dec_res        = '0;
      dec_res.opcode = in_opcode;
      if (in_enable) begin
         if ({1'b0, in_opcode} < OUT_W_L) begin
            dec_res.onehot = {{(OUT_W-1){1'b0}}, 1'b1} << in_opcode;
         end else begin
            dec_res.illegal = 1'b1;
         end
      end
   end

   decoder_skid #(.W(RES_W)) u_skid (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_data_i   (dec_res),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_bits)
   );

   assign out_res     = result_t'(out_bits);
   assign out_onehot  = out_res.onehot;
   assign out_illegal = out_res.illegal;
   assign out_opcode  = out_res.opcode;
   assign accept      = in_valid & in_ready;
   assign illegal_cnt = cnt_q;

   // Saturating illegal counter; clear beats a same-edge increment
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (accept && dec_res.illegal && cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: tb/tb_decoder_pipe.sv
// tb/tb_decoder_pipe.sv - self-checking bench for decoder_pipe (default and OUT_W=20/CNT_W=2 instances)
module tb_decoder_pipe;
   import decoder_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic        a_in_valid, a_in_ready, a_in_enable, a_out_valid, a_out_ready, a_out_illegal, a_cnt_clr;
   logic [4:0]  a_in_opcode, a_out_opcode;
   logic [31:0] a_out_onehot;
   logic [7:0]  a_illegal_cnt;

   logic        b_in_valid, b_in_ready, b_in_enable, b_out_valid, b_out_ready, b_out_illegal, b_cnt_clr;
   logic [4:0]  b_in_opcode, b_out_opcode;
   logic [19:0] b_out_onehot;
   logic [1:0]  b_illegal_cnt;

   int          pass_cnt  = 0;
   int          total_cnt = 0;
   bit          mon_en    = 1'b0;
   dec_result_t sb_q[$];

   decoder_pipe u_dut_a (
      .clk(clk), .rst_n(rst_n),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_opcode(a_in_opcode), .in_enable(a_in_enable),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_onehot(a_out_onehot),
      .out_illegal(a_out_illegal), .out_opcode(a_out_opcode),
      .illegal_cnt(a_illegal_cnt), .cnt_clr(a_cnt_clr)
   );

   decoder_pipe #(.IN_W(5), .OUT_W(20), .CNT_W(2)) u_dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_opcode(b_in_opcode), .in_enable(b_in_enable),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_onehot(b_out_onehot),
      .out_illegal(b_out_illegal), .out_opcode(b_out_opcode),
      .illegal_cnt(b_illegal_cnt), .cnt_clr(b_cnt_clr)
   );

   function automatic dec_result_t model_a(input logic [4:0] op, input logic en);
      dec_result_t r;
      r        = '0;
      r.opcode = op;
      if (en) r.onehot = 32'd1 << op;
      return r;
   endfunction

   // Scoreboard: push on accept, pop and compare on output transfer
   always @(negedge clk) begin
      if (mon_en) begin
         if (a_out_valid && a_out_ready) begin
            total_cnt++;
            if (sb_q.size() == 0) begin
               $display("FAIL sb_unexpected: got op=%0d onehot=%h, want no output", a_out_opcode, a_out_onehot);
            end else begin
               dec_result_t e;
               e = sb_q.pop_front();
               if ({a_out_onehot, a_out_illegal, a_out_opcode} !== e)
                  $display("FAIL sb_data: got onehot=%h ill=%b op=%0d, want onehot=%h ill=%b op=%0d",
                           a_out_onehot, a_out_illegal, a_out_opcode, e.onehot, e.illegal, e.opcode);
               else
                  pass_cnt++;
            end
         end
         if (a_in_valid && a_in_ready) sb_q.push_back(model_a(a_in_opcode, a_in_enable));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
      total_cnt++;
      if (sb_q.size() != 0) $display("FAIL %s_drain: got %0d pending, want 0", name, sb_q.size());
      else pass_cnt++;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      a_in_valid = 0; a_in_enable = 1; a_in_opcode = 0; a_out_ready = 1; a_cnt_clr = 0;
      b_in_valid = 0; b_in_enable = 1; b_in_opcode = 0; b_out_ready = 1; b_cnt_clr = 0;
      repeat (2) @(posedge clk);
      #1;
      total_cnt++; if (a_out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", a_out_valid); else pass_cnt++;
      total_cnt++; if (a_out_onehot !== 32'h0) $display("FAIL rst_onehot: got %h want 0", a_out_onehot); else pass_cnt++;
      total_cnt++; if (a_out_illegal !== 1'b0) $display("FAIL rst_illegal: got %b want 0", a_out_illegal); else pass_cnt++;
      total_cnt++; if (a_out_opcode !== 5'd0) $display("FAIL rst_opcode: got %0d want 0", a_out_opcode); else pass_cnt++;
      total_cnt++; if (a_illegal_cnt !== 8'd0) $display("FAIL rst_cnt: got %0d want 0", a_illegal_cnt); else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      total_cnt++; if (a_in_ready !== 1'b1) $display("FAIL rst_a_ready: got %b want 1", a_in_ready); else pass_cnt++;
      total_cnt++; if (b_in_ready !== 1'b1) $display("FAIL rst_b_ready: got %b want 1", b_in_ready); else pass_cnt++;
      mon_en = 1'b1;
   endtask

   task automatic test_stream();
      a_out_ready = 1; a_in_enable = 1; a_in_valid = 1; a_in_opcode = 5'd0;
      tick();
      a_in_opcode = 5'd16;
      @(negedge clk);
      total_cnt++; if (a_out_valid !== 1'b1 || a_out_onehot !== 32'h00000001) $display("FAIL stream_0: got v=%b %h want v=1 00000001", a_out_valid, a_out_onehot); else pass_cnt++;
      tick();
      a_in_opcode = 5'd31;
      @(negedge clk);
      total_cnt++; if (a_out_valid !== 1'b1 || a_out_onehot !== 32'h00010000) $display("FAIL stream_16: got v=%b %h want v=1 00010000", a_out_valid, a_out_onehot); else pass_cnt++;
      tick();
      a_in_valid = 0;
      @(negedge clk);
      total_cnt++; if (a_out_valid !== 1'b1 || a_out_onehot !== 32'h80000000) $display("FAIL stream_31: got v=%b %h want v=1 80000000", a_out_valid, a_out_onehot); else pass_cnt++;
      tick();
      @(negedge clk);
      total_cnt++; if (a_out_valid !== 1'b0) $display("FAIL stream_idle: got %b want 0", a_out_valid); else pass_cnt++;
      wait_drain("stream");
   endtask

   task automatic test_disabled();
      a_in_valid = 1; a_in_enable = 0; a_in_opcode = 5'd21;
      tick();
      a_in_valid = 0;
      @(negedge clk);
      total_cnt++; if (a_out_valid !== 1'b1) $display("FAIL dis_valid: got %b want 1", a_out_valid); else pass_cnt++;
      total_cnt++; if (a_out_onehot !== 32'h0) $display("FAIL dis_onehot: got %h want 0", a_out_onehot); else pass_cnt++;
      total_cnt++; if (a_out_illegal !== 1'b0) $display("FAIL dis_illegal: got %b want 0", a_out_illegal); else pass_cnt++;
      total_cnt++; if (a_illegal_cnt !== 8'd0) $display("FAIL dis_cnt: got %0d want 0", a_illegal_cnt); else pass_cnt++;
      a_in_enable = 1;
      wait_drain("disabled");
   endtask

   task automatic test_backpressure();
      bit got;
      a_out_ready = 0; a_in_valid = 1; a_in_opcode = 5'd3;
      tick();
      a_in_opcode = 5'd4;
      tick();
      a_in_opcode = 5'd5;
      @(negedge clk);
      total_cnt++; if (a_in_ready !== 1'b0) $display("FAIL bp_full_ready: got %b want 0", a_in_ready); else pass_cnt++;
      total_cnt++; if (a_out_valid !== 1'b1 || a_out_opcode !== 5'd3) $display("FAIL bp_main: got v=%b op=%0d want v=1 op=3", a_out_valid, a_out_opcode); else pass_cnt++;
      repeat (3) tick();
      @(negedge clk);
      total_cnt++; if (a_in_ready !== 1'b0) $display("FAIL bp_hold_ready: got %b want 0", a_in_ready); else pass_cnt++;
      total_cnt++; if (a_out_opcode !== 5'd3 || a_out_onehot !== 32'h8) $display("FAIL bp_hold_data: got op=%0d %h want op=3 00000008", a_out_opcode, a_out_onehot); else pass_cnt++;
      tick();
      a_out_ready = 1;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         got = a_in_ready;
         tick();
      end
      a_in_valid = 0;
      total_cnt++; if (got !== 1'b1) $display("FAIL bp_accept5: got %b want 1", got); else pass_cnt++;
      wait_drain("backpressure");
   endtask

   task automatic test_illegal_w20();
      b_out_ready = 1; b_in_enable = 1; b_in_valid = 1; b_in_opcode = 5'd19;
      tick();
      b_in_opcode = 5'd25;
      @(negedge clk);
      total_cnt++; if (b_out_onehot !== 20'h80000 || b_out_illegal !== 1'b0) $display("FAIL w20_19: got %h ill=%b want 80000 ill=0", b_out_onehot, b_out_illegal); else pass_cnt++;
      total_cnt++; if (b_illegal_cnt !== 2'd0) $display("FAIL w20_cnt0: got %0d want 0", b_illegal_cnt); else pass_cnt++;
      tick();
      b_in_valid = 0;
      @(negedge clk);
      total_cnt++; if (b_out_onehot !== 20'h0 || b_out_illegal !== 1'b1) $display("FAIL w20_25: got %h ill=%b want 00000 ill=1", b_out_onehot, b_out_illegal); else pass_cnt++;
      total_cnt++; if (b_illegal_cnt !== 2'd1) $display("FAIL w20_cnt1: got %0d want 1", b_illegal_cnt); else pass_cnt++;
      tick();
   endtask

   task automatic test_saturate();
      int exp_c;
      b_cnt_clr = 1;
      tick();
      b_cnt_clr = 0;
      @(negedge clk);
      total_cnt++; if (b_illegal_cnt !== 2'd0) $display("FAIL sat_clr0: got %0d want 0", b_illegal_cnt); else pass_cnt++;
      exp_c = 0;
      b_in_valid = 1; b_in_enable = 1;
      for (int k = 0; k < 5; k++) begin
         b_in_opcode = 5'(20 + k);
         tick();
         exp_c = (exp_c == 3) ? 3 : exp_c + 1;
         @(negedge clk);
         total_cnt++; if (b_illegal_cnt !== 2'(exp_c)) $display("FAIL sat_step%0d: got %0d want %0d", k, b_illegal_cnt, exp_c); else pass_cnt++;
      end
      b_in_opcode = 5'd26; b_cnt_clr = 1;
      tick();
      b_cnt_clr = 0; b_in_valid = 0;
      @(negedge clk);
      total_cnt++; if (b_illegal_cnt !== 2'd0) $display("FAIL sat_clr_wins: got %0d want 0", b_illegal_cnt); else pass_cnt++;
      total_cnt++; if (b_out_illegal !== 1'b1) $display("FAIL sat_6th_illegal: got %b want 1", b_out_illegal); else pass_cnt++;
      tick();
   endtask

   task automatic test_reset_midstream();
      mon_en = 1'b0;
      a_out_ready = 0; b_out_ready = 0;
      a_in_valid = 1; a_in_opcode = 5'd7; b_in_valid = 1; b_in_opcode = 5'd28;
      tick();
      a_in_opcode = 5'd8; b_in_opcode = 5'd29;
      tick();
      a_in_valid = 0; b_in_valid = 0;
      @(negedge clk);
      total_cnt++; if (a_in_ready !== 1'b0 || b_illegal_cnt !== 2'd2) $display("FAIL mid_pre: got rdy=%b cnt=%0d want rdy=0 cnt=2", a_in_ready, b_illegal_cnt); else pass_cnt++;
      #2 rst_n = 1'b0;
      #1;
      total_cnt++; if (a_out_valid !== 1'b0) $display("FAIL mid_valid: got %b want 0", a_out_valid); else pass_cnt++;
      total_cnt++; if (a_out_onehot !== 32'h0) $display("FAIL mid_onehot: got %h want 0", a_out_onehot); else pass_cnt++;
      total_cnt++; if (b_out_valid !== 1'b0) $display("FAIL mid_b_valid: got %b want 0", b_out_valid); else pass_cnt++;
      total_cnt++; if (b_illegal_cnt !== 2'd0) $display("FAIL mid_cnt: got %0d want 0", b_illegal_cnt); else pass_cnt++;
      sb_q.delete();
      tick();
      rst_n = 1'b1;
      tick();
      @(negedge clk);
      total_cnt++; if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) $display("FAIL mid_ready: got a=%b b=%b want 1 1", a_in_ready, b_in_ready); else pass_cnt++;
      total_cnt++; if (a_out_valid !== 1'b0) $display("FAIL mid_no_replay: got %b want 0", a_out_valid); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_disabled();
      test_backpressure();
      test_illegal_w20();
      test_saturate();
      test_reset_midstream();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
